// File: rtl/hazard_ctrl_unit.sv
// Hazard/flush controller for the 5-stage RISC-V pipeline: load-use stalls, redirect flushes,
// E-stage forwarding select, post-reset bubble fill and saturating stall/flush counters.
module hazard_ctrl_unit #(
  parameter int STARTUP_CYC = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic [1:0]       result_src_e,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             pc_src_e,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             stall_w,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             o_dbg_state
);

  // Handshake: none; every input is sampled combinationally each cycle and the
  // pipeline registers obey stall/flush in the same cycle they are asserted.

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [3:0]       INIT_LAST = 4'(STARTUP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_init_cnt, w_init_cnt_nxt;
  logic [CNT_W-1:0] r_stall_count, r_flush_count;
  logic             w_lwstall, w_run, w_stall_inc, w_flush_inc;

  assign w_lwstall = (result_src_e == 2'b01) && (rd_e != 5'd0) &&
                     ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign w_run     = (r_state == S_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_INIT;
      r_init_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // INIT counts regardless of mem_busy; RUN is terminal until reset.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    if (r_state == S_INIT) begin
      w_init_cnt_nxt = r_init_cnt + 4'd1;
      if (r_init_cnt == INIT_LAST) w_state_nxt = S_RUN;
    end
  end

  always_comb begin
    stall_f = mem_busy | w_lwstall;
    stall_d = mem_busy | w_lwstall;
    stall_e = mem_busy;
    stall_m = mem_busy;
    stall_w = mem_busy;
    flush_d = 1'b1;
    flush_e = 1'b1;
    if (w_run) begin
      flush_d = !mem_busy && pc_src_e;
      flush_e = !mem_busy && (w_lwstall || pc_src_e);
    end
  end

  // M-stage result is newer than W, so it wins; x0 is never forwarded.
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (reg_write_m && rd_m != 5'd0 && rd_m == rs1_e)      forward_a_e = 2'b10;
    else if (reg_write_w && rd_w != 5'd0 && rd_w == rs1_e) forward_a_e = 2'b01;
    if (reg_write_m && rd_m != 5'd0 && rd_m == rs2_e)      forward_b_e = 2'b10;
    else if (reg_write_w && rd_w != 5'd0 && rd_w == rs2_e) forward_b_e = 2'b01;
  end

  assign w_stall_inc = w_run && stall_f;
  assign w_flush_inc = w_run && pc_src_e && !mem_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else if (cnt_clr) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_stall_inc && r_stall_count != '1) r_stall_count <= r_stall_count + CNT_ONE;
      if (w_flush_inc && r_flush_count != '1) r_flush_count <= r_flush_count + CNT_ONE;
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: startup flush, load-use, forwarding, redirect,
// memory freeze, counter saturation/clear and asynchronous reset.
module tb_hazard_ctrl_unit;

  logic        clk, rst;
  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0]  result_src_e;
  logic        reg_write_m, reg_write_w, pc_src_e, mem_busy, cnt_clr;
  logic        stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e;
  logic [1:0]  forward_a_e, forward_b_e;
  logic [15:0] stall_count, flush_count;
  logic        o_dbg_state;

  int total = 0;
  int bad   = 0;

  hazard_ctrl_unit #(.STARTUP_CYC(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .result_src_e(result_src_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .pc_src_e(pc_src_e), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m), .stall_w(stall_w),
    .flush_d(flush_d), .flush_e(flush_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_count(stall_count), .flush_count(flush_count),
    .o_dbg_state(o_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
    rd_e = 0; rd_m = 0; rd_w = 0; result_src_e = 2'b00;
    reg_write_m = 0; reg_write_w = 0; pc_src_e = 0; mem_busy = 0; cnt_clr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    #12;
    total++; if ({flush_d, flush_e} !== 2'b11) begin bad++; $display("FAIL reset_flush got=%b exp=11", {flush_d, flush_e}); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_stall_count got=%h exp=0000", stall_count); end
    total++; if (flush_count !== 16'd0) begin bad++; $display("FAIL reset_flush_count got=%h exp=0000", flush_count); end
    total++; if (o_dbg_state !== 1'b0) begin bad++; $display("FAIL reset_state got=%b exp=0", o_dbg_state); end
    mem_busy = 1'b1;
    #1;
    total++; if ({stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e} !== 7'b1111111) begin
      bad++; $display("FAIL init_busy got=%b exp=1111111", {stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e}); end
    mem_busy = 1'b0;
  endtask

  task automatic test_startup();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++; if ({flush_d, flush_e} !== 2'b11) begin bad++; $display("FAIL startup_c0 got=%b exp=11", {flush_d, flush_e}); end
    tick();
    total++; if ({flush_d, flush_e} !== 2'b11) begin bad++; $display("FAIL startup_c1 got=%b exp=11", {flush_d, flush_e}); end
    tick();
    total++; if ({flush_d, flush_e} !== 2'b00) begin bad++; $display("FAIL startup_c2 got=%b exp=00", {flush_d, flush_e}); end
    total++; if (o_dbg_state !== 1'b1) begin bad++; $display("FAIL startup_state got=%b exp=1", o_dbg_state); end
    total++; if ({stall_count, flush_count} !== 32'd0) begin bad++; $display("FAIL startup_counts got=%h exp=00000000", {stall_count, flush_count}); end
  endtask

  task automatic test_load_use();
    result_src_e = 2'b01; rd_e = 5'd0; rs1_d = 5'd0;
    #1;
    total++; if ({stall_f, flush_e} !== 2'b00) begin bad++; $display("FAIL lw_x0 got=%b exp=00", {stall_f, flush_e}); end
    rd_e = 5'd5; rs1_d = 5'd5;
    #1;
    total++; if ({stall_f, stall_d, stall_e, flush_d, flush_e} !== 5'b11001) begin
      bad++; $display("FAIL lw_stall got=%b exp=11001", {stall_f, stall_d, stall_e, flush_d, flush_e}); end
    tick();
    clear_inputs();
    #1;
    total++; if (stall_count !== 16'd1) begin bad++; $display("FAIL lw_count got=%h exp=0001", stall_count); end
    total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL lw_release got=%b exp=0", stall_f); end
    rd_e = 5'd9; result_src_e = 2'b01; rs2_d = 5'd9;
    #1;
    total++; if ({stall_d, flush_e} !== 2'b11) begin bad++; $display("FAIL lw_rs2 got=%b exp=11", {stall_d, flush_e}); end
    clear_inputs();
    result_src_e = 2'b00; rd_e = 5'd9; rs2_d = 5'd9;
    #1;
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL nonload got=%b exp=0", stall_d); end
    clear_inputs();
  endtask

  task automatic test_forwarding();
    rd_m = 5'd7; rd_w = 5'd7; reg_write_m = 1; reg_write_w = 1; rs1_e = 5'd7; rs2_e = 5'd3;
    #1;
    total++; if ({forward_a_e, forward_b_e} !== 4'b1000) begin bad++; $display("FAIL fwd_m got=%b exp=1000", {forward_a_e, forward_b_e}); end
    reg_write_m = 0;
    #1;
    total++; if (forward_a_e !== 2'b01) begin bad++; $display("FAIL fwd_w got=%b exp=01", forward_a_e); end
    rd_m = 0; rd_w = 0; rs1_e = 0; reg_write_m = 1;
    #1;
    total++; if (forward_a_e !== 2'b00) begin bad++; $display("FAIL fwd_x0 got=%b exp=00", forward_a_e); end
    rd_m = 5'd3; rd_w = 5'd4; rs1_e = 5'd4; rs2_e = 5'd3;
    #1;
    total++; if ({forward_a_e, forward_b_e} !== 4'b0110) begin bad++; $display("FAIL fwd_mix got=%b exp=0110", {forward_a_e, forward_b_e}); end
    clear_inputs();
  endtask

  task automatic test_redirect();
    pc_src_e = 1; result_src_e = 2'b01; rd_e = 5'd6; rs1_d = 5'd6;
    #1;
    total++; if ({flush_d, flush_e, stall_f} !== 3'b111) begin bad++; $display("FAIL redir_lw got=%b exp=111", {flush_d, flush_e, stall_f}); end
    tick();
    clear_inputs();
    #1;
    total++; if (flush_count !== 16'd1) begin bad++; $display("FAIL redir_fcount got=%h exp=0001", flush_count); end
    total++; if (stall_count !== 16'd2) begin bad++; $display("FAIL redir_scount got=%h exp=0002", stall_count); end
  endtask

  task automatic test_mem_busy();
    mem_busy = 1; pc_src_e = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e} !== 7'b1111100) begin
        bad++; $display("FAIL busy_c%0d got=%b exp=1111100", i, {stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e}); end
      tick();
    end
    total++; if (stall_count !== 16'd5) begin bad++; $display("FAIL busy_scount got=%h exp=0005", stall_count); end
    total++; if (flush_count !== 16'd1) begin bad++; $display("FAIL busy_fcount got=%h exp=0001", flush_count); end
    mem_busy = 0;
    #1;
    total++; if ({flush_d, flush_e, stall_f} !== 3'b110) begin bad++; $display("FAIL busy_release got=%b exp=110", {flush_d, flush_e, stall_f}); end
    tick();
    clear_inputs();
    #1;
    total++; if (flush_count !== 16'd2) begin bad++; $display("FAIL release_fcount got=%h exp=0002", flush_count); end
    total++; if (stall_count !== 16'd5) begin bad++; $display("FAIL release_scount got=%h exp=0005", stall_count); end
  endtask

  task automatic test_saturate_clear_reset();
    result_src_e = 2'b01; rd_e = 5'd8; rs1_d = 5'd8;
    for (int i = 0; i < 65530; i++) tick();
    total++; if (stall_count !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%h exp=FFFF", stall_count); end
    for (int i = 0; i < 4; i++) tick();
    total++; if (stall_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=FFFF", stall_count); end
    pc_src_e = 1; cnt_clr = 1;
    tick();
    pc_src_e = 0; cnt_clr = 0;
    #1;
    total++; if ({stall_count, flush_count} !== 32'd0) begin bad++; $display("FAIL clr got=%h exp=00000000", {stall_count, flush_count}); end
    tick();
    total++; if (stall_count !== 16'd1) begin bad++; $display("FAIL post_clr got=%h exp=0001", stall_count); end
    #2;
    rst = 1'b0;
    #1;
    total++; if ({flush_d, flush_e, stall_f, stall_e} !== 4'b1110) begin bad++; $display("FAIL async_rst_out got=%b exp=1110", {flush_d, flush_e, stall_f, stall_e}); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL async_rst_count got=%h exp=0000", stall_count); end
    total++; if (o_dbg_state !== 1'b0) begin bad++; $display("FAIL async_rst_state got=%b exp=0", o_dbg_state); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_startup();
    test_load_use();
    test_forwarding();
    test_redirect();
    test_mem_busy();
    test_saturate_clear_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
